regfile_mp: RTL and testbench

- Parametrised successor to the single-write, two-read integer register file.
- Supports N read ports, an optional same-cycle write-to-read bypass and an optional hard-wired zero register.
- Holds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight writebacks.
- Sits between decode (read ports, busy set) and writeback (write port, busy clear).

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with an
// optional write-to-read bypass, an optional hard-wired zero register and a
// per-register busy scoreboard for RAW hazard detection at decode.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   write_en       writeback valid
//   rd_addr        writeback destination
//   rd_data        writeback data
//   r_addr         NUM_RD packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   r_data         NUM_RD packed read data, same packing
//   r_busy         per-port busy flag of the addressed register
//   busy_set_en    decode issued an instruction with a destination
//   busy_set_addr  that destination
//   flush          synchronous clear of all busy bits
//   busy_cnt       registered population count of the busy vector
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int CNT_WIDTH = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
  output logic [NUM_RD-1:0]            r_busy,
  input  logic                         busy_set_en,
  input  logic [ADDR_WIDTH-1:0]        busy_set_addr,
  input  logic                         flush,
  output logic [CNT_WIDTH-1:0]         busy_cnt
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  wr_ok;
  logic                  set_ok;
  logic                  inc;
  logic                  dec;

  // Writes and busy-sets targeting the hard-wired zero register are dropped.
  assign wr_ok  = write_en    && !((ZERO_REG != 0) && (rd_addr == '0));
  assign set_ok = busy_set_en && !((ZERO_REG != 0) && (busy_set_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Set beats clear on the same register (newer producer); flush beats both.
  // The counter tracks the vector incrementally: a clear of a register that is
  // simultaneously re-set must not decrement.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[rd_addr]       = 1'b0;
    if (set_ok) busy_nxt[busy_set_addr] = 1'b1;
    if (flush)  busy_nxt                = '0;

    inc = set_ok && !busy[busy_set_addr];
    dec = wr_ok && busy[rd_addr] && !(set_ok && (busy_set_addr == rd_addr));

    if (flush) cnt_nxt = '0;
    else       cnt_nxt = busy_cnt + {{(CNT_WIDTH-1){1'b0}}, inc}
                                  - {{(CNT_WIDTH-1){1'b0}}, dec};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Outputs are forced to 0 while reset is held, so a bypass hit cannot leak
  // write data during reset.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit;
    a      = '0;
    hit    = 1'b0;
    r_data = '0;
    r_busy = '0;
    if (rst_n) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        a   = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        hit = (BYPASS != 0) && write_en && (rd_addr == a);
        if ((ZERO_REG != 0) && (a == '0)) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
          r_busy[k]                          = 1'b0;
        end else if (hit) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
          r_busy[k]                          = 1'b0;
        end else begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[a];
          r_busy[k]                          = busy[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [19:0] r_addr;
  logic        busy_set_en;
  logic [4:0]  busy_set_addr;
  logic        flush;

  logic [127:0] r_data0;
  logic [3:0]   r_busy0;
  logic [5:0]   cnt0;
  logic [63:0]  r_data1;
  logic [1:0]   r_busy1;
  logic [5:0]   cnt1;

  // dut0: 4 read ports with bypass; dut1: 2 read ports without bypass.
  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .r_addr(r_addr), .r_data(r_data0), .r_busy(r_busy0), .busy_set_en(busy_set_en),
    .busy_set_addr(busy_set_addr), .flush(flush), .busy_cnt(cnt0));

  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .r_addr(r_addr[9:0]), .r_data(r_data1), .r_busy(r_busy1), .busy_set_en(busy_set_en),
    .busy_set_addr(busy_set_addr), .flush(flush), .busy_cnt(cnt1));

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;   // 0 data, 1 busy, 2 count
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(exp_t e);
    logic [31:0] v;
    v = '0;
    case (e.kind)
      0: v = (e.dut == 0) ? r_data0[e.port*32 +: 32] : r_data1[e.port*32 +: 32];
      1: v = (e.dut == 0) ? {31'b0, r_busy0[e.port]} : {31'b0, r_busy1[e.port]};
      default: v = (e.dut == 0) ? {26'b0, cnt0} : {26'b0, cnt1};
    endcase
    return v;
  endfunction

  // Monitor: outputs are valid mid-cycle; pop every expectation due now.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = actual(e);
      vectors++;
      if (e.cyc != cyc || a !== e.val) begin
        miscompares++;
        $display("FAIL %s: dut%0d port%0d got %h expected %h (cycle %0d)",
                 e.name, e.dut, e.port, a, e.val, e.cyc);
      end
    end
  end

  task automatic push(int dut, int kind, int port, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.port = port; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic ed(int dut, int p, logic [31:0] v, string n); push(dut, 0, p, v, n); endtask
  task automatic eb(int dut, int p, logic [31:0] v, string n); push(dut, 1, p, v, n); endtask
  task automatic ed2(int p, logic [31:0] v, string n);
    push(0, 0, p, v, n);
    if (p < 2) push(1, 0, p, v, n);
  endtask
  task automatic eb2(int p, logic [31:0] v, string n);
    push(0, 1, p, v, n);
    if (p < 2) push(1, 1, p, v, n);
  endtask
  task automatic ec2(logic [31:0] v, string n);
    push(0, 2, 0, v, n);
    push(1, 2, 0, v, n);
  endtask

  task automatic idle();
    write_en = 0; rd_addr = '0; rd_data = '0; busy_set_en = 0;
    busy_set_addr = '0; flush = 0; r_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1; idle();
  endtask

  task automatic rd(int p, int a);
    r_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic wr(int a, logic [31:0] d);
    write_en = 1; rd_addr = 5'(a); rd_data = d;
  endtask

  task automatic bset(int a);
    busy_set_en = 1; busy_set_addr = 5'(a);
  endtask

  initial begin
    idle();
    rst_n = 0;

    // Reset held: outputs zero even with a bypass-eligible write present
    step(); wr(7, 32'hFFFF0000); bset(3);
    for (int p = 0; p < 4; p++) begin
      rd(p, 7); ed2(p, 0, "rst_data"); eb2(p, 0, "rst_busy");
    end
    ec2(0, "rst_cnt");
    step(); rst_n = 1; rd(0, 7); rd(1, 3);
    ed2(0, 0, "rst_discard_wr"); eb2(1, 0, "rst_discard_set"); ec2(0, "rst_discard_cnt");

    // Write reg5 then reset mid-run
    step(); wr(5, 32'hDEADBEEF);
    step(); rd(0, 5); ed2(0, 32'hDEADBEEF, "wr5");
    step(); rst_n = 0;
    for (int p = 0; p < 4; p++) begin rd(p, 5); ed2(p, 0, "async_rst"); end
    step(); rst_n = 1; rd(0, 5); ed2(0, 0, "post_rst5"); ec2(0, "post_rst_cnt");

    // Zero register
    step(); wr(0, 32'h1234); rd(0, 0); ed2(0, 0, "zero_wr_bypass");
    step(); rd(0, 0); ed2(0, 0, "zero_rd");

    // Bypass vs no bypass, with reg7 busy
    step(); bset(7);
    step(); wr(7, 32'hA5A5A5A5); rd(0, 7);
    ed(0, 0, 32'hA5A5A5A5, "byp_data"); eb(0, 0, 0, "byp_busy");
    ed(1, 0, 32'h0, "nobyp_old"); eb(1, 0, 1, "nobyp_busy"); ec2(1, "byp_cnt");
    step(); rd(0, 7); ed2(0, 32'hA5A5A5A5, "byp_next"); eb2(0, 0, "byp_next_busy");
    ec2(0, "byp_next_cnt");

    // Scoreboard lifecycle
    step(); bset(3);
    step(); rd(0, 3); eb2(0, 1, "life_busy"); ec2(1, "life_cnt");
    step(); wr(3, 32'h55); rd(0, 3);
    ed(0, 0, 32'h55, "life_byp"); eb(0, 0, 0, "life_byp_busy");
    ed(1, 0, 32'h0, "life_old"); eb(1, 0, 1, "life_old_busy");
    step(); rd(0, 3); ed2(0, 32'h55, "life_data"); eb2(0, 0, "life_clear"); ec2(0, "life_cnt0");

    // Busy-set of register 0 is ignored
    step(); bset(0);
    step(); rd(0, 0); eb2(0, 0, "zero_busy"); ec2(0, "zero_cnt");

    // Set/clear collision
    step(); bset(9);
    step(); wr(9, 32'h99); bset(9); ec2(1, "coll_cnt_pre");
    step(); rd(0, 9); ed2(0, 32'h99, "coll_data"); eb2(0, 1, "coll_busy"); ec2(1, "coll_cnt");
    step(); wr(9, 32'h9A); bset(4); ec2(1, "net_cnt_pre");
    step(); rd(0, 9); rd(1, 4);
    ed2(0, 32'h9A, "net_data"); eb2(0, 0, "net_clr"); eb2(1, 1, "net_set"); ec2(1, "net_cnt");

    // Flush
    step(); bset(1);
    step(); bset(2); ec2(2, "fl_cnt2");
    step(); bset(31); ec2(3, "fl_cnt3");
    step(); flush = 1; wr(2, 32'h77); bset(6); rd(0, 2); ec2(4, "fl_cnt4");
    ed(0, 0, 32'h77, "fl_byp"); eb(0, 0, 0, "fl_byp_busy");
    ed(1, 0, 32'h0, "fl_old"); eb(1, 0, 1, "fl_old_busy");
    step(); rd(0, 1); rd(1, 2); rd(2, 31); rd(3, 6);
    for (int p = 0; p < 4; p++) eb2(p, 0, "fl_busy");
    ed2(1, 32'h77, "fl_data"); ec2(0, "fl_cnt");

    // Multi-port reads
    step(); wr(1, 32'h11);
    step(); wr(2, 32'h22);
    step(); wr(3, 32'h33);
    step(); wr(4, 32'h44);
    step(); rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 4);
    ed2(0, 32'h11, "mp0"); ed2(1, 32'h22, "mp1"); ed2(2, 32'h33, "mp2"); ed2(3, 32'h44, "mp3");
    step(); rd(0, 2); rd(1, 2); rd(2, 4); rd(3, 2);
    ed2(0, 32'h22, "alias0"); ed2(1, 32'h22, "alias1"); ed2(2, 32'h44, "alias2"); ed2(3, 32'h22, "alias3");
    step(); rd(0, 0); rd(1, 4); rd(2, 0); rd(3, 1);
    ed2(0, 32'h0, "mix0"); ed2(1, 32'h44, "mix1"); ed2(2, 32'h0, "mix2"); ed2(3, 32'h11, "mix3");

    step();
    step();
    if (q.size() != 0) begin
      miscompares += q.size();
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
